// File: rtl/operand_fetch_stage_pkg.sv
// Shared constants for the operand fetch stage: geometry, ALU function encodings
// and status bit positions.
package operand_fetch_stage_pkg;

    localparam int WIDTH    = 64;
    localparam int NREGS    = 32;
    localparam int ZERO_REG = 31;
    localparam int AW       = $clog2(NREGS);

    typedef enum logic [4:0] {
        FS_AND = 5'b00000,
        FS_OR  = 5'b00100,
        FS_ADD = 5'b01000,
        FS_SUB = 5'b01001,
        FS_XOR = 5'b01100,
        FS_SHL = 5'b10000,
        FS_SHR = 5'b10100
    } fs_e;

    localparam int ST_V = 3;
    localparam int ST_C = 2;
    localparam int ST_N = 1;
    localparam int ST_Z = 0;

endpackage

// File: rtl/operand_fetch_stage_regfile_2r1w.sv
// Two-read / one-write register array with a hard-wired zero register and
// write-before-read bypass on both read ports.
module regfile_2r1w
    import operand_fetch_stage_pkg::*;
#(
    parameter int DW     = WIDTH,
    parameter int NR     = NREGS,
    parameter int ZR_IDX = ZERO_REG,
    parameter int AWID   = $clog2(NR)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            we,
    input  logic [AWID-1:0] wa,
    input  logic [DW-1:0]   wd,
    input  logic [AWID-1:0] ra_a,
    input  logic [AWID-1:0] ra_b,
    output logic [DW-1:0]   rd_a,
    output logic [DW-1:0]   rd_b
);

    localparam logic [AWID-1:0] ZR = AWID'(ZR_IDX);

    logic [DW-1:0] mem [NR];
    logic          wr_live;

    assign wr_live = we && (wa != ZR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NR; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_live) begin
            mem[wa] <= wd;
        end
    end

    // Zero register wins over bypass; a write to it is never live anyway.
    always_comb begin
        rd_a = mem[ra_a];
        if (ra_a == ZR) begin
            rd_a = '0;
        end else if (wr_live && (wa == ra_a)) begin
            rd_a = wd;
        end
    end

    always_comb begin
        rd_b = mem[ra_b];
        if (ra_b == ZR) begin
            rd_b = '0;
        end else if (wr_live && (wa == ra_b)) begin
            rd_b = wd;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand stage ahead of the ALU: register file read, A/B/FS operand latches with
// stall hold, and the ALU status flag register.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int WIDTH_P    = WIDTH,
    parameter int NREGS_P    = NREGS,
    parameter int ZERO_REG_P = ZERO_REG
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        in_valid,
    input  logic                        stall,
    input  logic [$clog2(NREGS_P)-1:0]  SA,
    input  logic [$clog2(NREGS_P)-1:0]  SB,
    input  logic [4:0]                  FS_in,
    input  logic                        W,
    input  logic [$clog2(NREGS_P)-1:0]  DA,
    input  logic [WIDTH_P-1:0]          D,
    input  logic                        SL,
    input  logic [3:0]                  status_in,
    output logic [WIDTH_P-1:0]          A,
    output logic [WIDTH_P-1:0]          B,
    output logic [4:0]                  FS,
    output logic                        out_valid,
    output logic [3:0]                  flags
);

    logic [WIDTH_P-1:0] read_a;
    logic [WIDTH_P-1:0] read_b;

    regfile_2r1w #(
        .DW     (WIDTH_P),
        .NR     (NREGS_P),
        .ZR_IDX (ZERO_REG_P)
    ) u_regfile (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (W),
        .wa      (DA),
        .wd      (D),
        .ra_a    (SA),
        .ra_b    (SB),
        .rd_a    (read_a),
        .rd_b    (read_b)
    );

    // Latches track the read ports even when in_valid is low; only out_valid qualifies them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            A         <= '0;
            B         <= '0;
            FS        <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            A         <= read_a;
            B         <= read_b;
            FS        <= FS_in;
            out_valid <= in_valid;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flags <= '0;
        end else if (SL) begin
            flags <= status_in;
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: directed operations push expected A/B/FS,
// a negedge monitor pops and compares each freshly latched valid operation.
module tb_operand_fetch_stage;
    import operand_fetch_stage_pkg::*;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  fs;
        string       name;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        stall;
    logic [4:0]  SA, SB, FS_in, DA;
    logic        W;
    logic [63:0] D;
    logic        SL;
    logic [3:0]  status_in;
    logic [63:0] A, B;
    logic [4:0]  FS;
    logic        out_valid;
    logic [3:0]  flags;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic fresh = 1'b0;

    operand_fetch_stage dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .stall     (stall),
        .SA        (SA),
        .SB        (SB),
        .FS_in     (FS_in),
        .W         (W),
        .DA        (DA),
        .D         (D),
        .SL        (SL),
        .status_in (status_in),
        .A         (A),
        .B         (B),
        .FS        (FS),
        .out_valid (out_valid),
        .flags     (flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // An operation is new at the output only if the last edge was not stalled.
    always @(posedge clock) fresh <= !stall;

    always @(negedge clock) begin
        if (reset_n && out_valid && fresh) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_op: got A=%h B=%h FS=%b, required no valid output", A, B, FS);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (A !== e.a || B !== e.b || FS !== e.fs) begin
                    n_bad++;
                    $display("FAIL %s: got A=%h B=%h FS=%b, required A=%h B=%h FS=%b",
                             e.name, A, B, FS, e.a, e.b, e.fs);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic wr(input logic [4:0] da, input logic [63:0] d);
        W = 1'b1; DA = da; D = d; in_valid = 1'b0;
        cyc();
        W = 1'b0;
    endtask

    task automatic issue(input string name, input logic [4:0] sa, input logic [4:0] sb,
                         input logic [4:0] fs, input logic [63:0] ea, input logic [63:0] eb);
        exp_t e;
        SA = sa; SB = sb; FS_in = fs; in_valid = 1'b1;
        e.a = ea; e.b = eb; e.fs = fs; e.name = name;
        q.push_back(e);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; stall = 1'b0; SA = '0; SB = '0; FS_in = '0;
        W = 1'b0; DA = '0; D = '0; SL = 1'b0; status_in = '0;
        repeat (2) cyc();
        reset_n = 1'b1;
        cyc();

        // Load registers, check a normal read, then reset and check everything clears.
        for (int i = 1; i <= 5; i++) wr(5'(i), 64'(i * 100));
        issue("preload_read", 5'd2, 5'd3, FS_ADD, 64'd200, 64'd300);
        cyc();
        in_valid = 1'b0;
        SL = 1'b1; status_in = 4'b1111;
        cyc();
        SL = 1'b0;
        #6;
        reset_n = 1'b0;
        #1;
        chk("reset_A", A, 64'd0);
        chk("reset_B", B, 64'd0);
        chk("reset_flags", 64'(flags), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        issue("read_r5_after_reset", 5'd5, 5'd1, FS_ADD, 64'd0, 64'd0);
        cyc();

        // Write then read, with XZR on port B.
        in_valid = 1'b0;
        wr(5'd3, 64'd2);
        issue("r3_and_xzr", 5'd3, 5'd31, FS_ADD, 64'd2, 64'd0);
        cyc();

        // Same-cycle bypass on both ports.
        W = 1'b1; DA = 5'd7; D = 64'h8000000000000000;
        issue("bypass_both", 5'd7, 5'd7, FS_SUB, 64'h8000000000000000, 64'h8000000000000000);
        cyc();
        W = 1'b0;

        // Bypass on port B only.
        W = 1'b1; DA = 5'd13; D = 64'hDEADBEEF_CAFEF00D;
        issue("bypass_b_only", 5'd3, 5'd13, FS_XOR, 64'd2, 64'hDEADBEEF_CAFEF00D);
        cyc();
        W = 1'b0;

        // Writes to XZR are discarded; idle cycle drops out_valid.
        wr(5'd31, 64'hFF);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        issue("xzr_after_write", 5'd31, 5'd31, FS_AND, 64'd0, 64'd0);
        cyc();

        // Latch A=1,B=15, then stall three cycles while writing r4.
        in_valid = 1'b0;
        wr(5'd10, 64'd1);
        wr(5'd11, 64'd15);
        issue("pre_stall_latch", 5'd10, 5'd11, FS_SUB, 64'd1, 64'd15);
        cyc();
        stall = 1'b1; SA = 5'd7; SB = 5'd3; FS_in = FS_XOR; in_valid = 1'b1;
        W = 1'b1; DA = 5'd4; D = 64'd9;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_hold_A", A, 64'd1);
            chk("stall_hold_B", B, 64'd15);
            chk("stall_hold_FS", 64'(FS), 64'(FS_SUB));
            chk("stall_hold_valid", 64'(out_valid), 64'd1);
        end
        stall = 1'b0; W = 1'b0;
        issue("r4_after_stall", 5'd4, 5'd10, FS_OR, 64'd9, 64'd1);
        cyc();

        // Stale operand: write r12 after it was latched does not touch A.
        issue("r12_before_write", 5'd12, 5'd11, FS_SHL, 64'd0, 64'd15);
        cyc();
        in_valid = 1'b0; SA = 5'd11; SB = 5'd11;
        W = 1'b1; DA = 5'd12; D = 64'd55;
        stall = 1'b1;
        cyc();
        W = 1'b0;
        chk("stale_A", A, 64'd0);
        stall = 1'b0;
        issue("r12_after_write", 5'd12, 5'd31, FS_SHR, 64'd55, 64'd0);
        cyc();
        in_valid = 1'b0;

        // Flags load/hold, then async clear.
        SL = 1'b1; status_in = 4'b1010;
        cyc();
        chk("flags_load", 64'(flags), 64'b1010);
        SL = 1'b0; status_in = 4'b0001;
        cyc();
        chk("flags_hold", 64'(flags), 64'b1010);
        #2;
        reset_n = 1'b0;
        #1;
        chk("flags_async_clear", 64'(flags), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (3) cyc();

        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
